// File: rtl/memory_pkg.sv
// Shared memory-bus types for the data memory and its two-port arbiter.
//   mem_req_t       : one requester's access attributes (we, be, addr, wdata)
//   mem_arb_state_t : arbiter sequencing states
package memory_pkg;

  localparam int unsigned MEM_ARB_PORTS = 2;
  localparam int unsigned MEM_ADDR_W    = 32;
  localparam int unsigned MEM_DATA_W    = 32;
  localparam int unsigned MEM_BE_W      = 4;

  typedef struct packed {
    logic                  we;
    logic [MEM_BE_W-1:0]   be;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req     : request vector, bit x = requester x
//   rr_ptr  : port favoured when both request
//   winner  : index of the selected port (meaningful when any_req)
//   any_req : at least one request is present
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       winner,
  output logic       any_req
);

  // A lone request wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    any_req = |req;
    winner  = req[1];
    if (req == 2'b11) begin
      winner = rr_ptr;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   m0_* / m1_*           : requester ports (req/we/be/addr/wdata in, rdata/ready out)
//   mem_req_o..mem_wdata_o: access issued to the memory
//   mem_rdata_i           : memory read data, valid the cycle after acceptance
//   mem_ready_i           : memory accepts when mem_req_o && mem_ready_i
module data_mem_arbiter
  import memory_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [MEM_BE_W-1:0]   m0_be_i,
  input  logic [MEM_ADDR_W-1:0] m0_addr_i,
  input  logic [MEM_DATA_W-1:0] m0_wdata_i,
  output logic [MEM_DATA_W-1:0] m0_rdata_o,
  output logic                  m0_ready_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [MEM_BE_W-1:0]   m1_be_i,
  input  logic [MEM_ADDR_W-1:0] m1_addr_i,
  input  logic [MEM_DATA_W-1:0] m1_wdata_i,
  output logic [MEM_DATA_W-1:0] m1_rdata_o,
  output logic                  m1_ready_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_BE_W-1:0]   mem_be_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [MEM_DATA_W-1:0] mem_wdata_o,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i,
  input  logic                  mem_ready_i
);

  mem_arb_state_t        state_q;
  logic                  rr_q;
  logic                  owner_q;
  logic [MEM_DATA_W-1:0] rdata_hold_q [MEM_ARB_PORTS];

  mem_req_t port_req [MEM_ARB_PORTS];
  mem_req_t sel_req;
  logic     sel;
  logic     winner;
  logic     any_req;
  logic     issue;
  logic     resp0;
  logic     resp1;

  // Gather each requester's attributes into one bus payload.
  always_comb begin
    port_req[0].we    = m0_we_i;
    port_req[0].be    = m0_be_i;
    port_req[0].addr  = m0_addr_i;
    port_req[0].wdata = m0_wdata_i;
    port_req[1].we    = m1_we_i;
    port_req[1].be    = m1_be_i;
    port_req[1].addr  = m1_addr_i;
    port_req[1].wdata = m1_wdata_i;
  end

  rr_arbiter2 u_rr_arbiter2 (
    .req     ({m1_req_i, m0_req_i}),
    .rr_ptr  (rr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // In IDLE the fresh winner drives the bus; while stalled only the owner does.
  always_comb begin
    sel     = (state_q == IDLE) ? winner : owner_q;
    sel_req = port_req[sel];
    issue   = !rst_i && (((state_q == IDLE) && any_req) || (state_q == WAIT));
  end

  // Memory side: idle bus is all-zero, which also covers the reset override.
  always_comb begin
    mem_req_o   = issue;
    mem_we_o    = issue ? sel_req.we    : 1'b0;
    mem_be_o    = issue ? sel_req.be    : '0;
    mem_addr_o  = issue ? sel_req.addr  : '0;
    mem_wdata_o = issue ? sel_req.wdata : '0;
  end

  // Requester side: live memory data to the owner in RESP, held data otherwise.
  always_comb begin
    resp0      = !rst_i && (state_q == RESP) && (owner_q == 1'b0);
    resp1      = !rst_i && (state_q == RESP) && (owner_q == 1'b1);
    m0_ready_o = resp0;
    m1_ready_o = resp1;
    m0_rdata_o = rst_i ? '0 : (resp0 ? mem_rdata_i : rdata_hold_q[0]);
    m1_rdata_o = rst_i ? '0 : (resp1 ? mem_rdata_i : rdata_hold_q[1]);
  end

  // Issue/response sequencing, ownership, fairness pointer and read-data hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      for (int unsigned i = 0; i < MEM_ARB_PORTS; i++) begin
        rdata_hold_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            state_q <= mem_ready_i ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (mem_ready_i) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          rdata_hold_q[owner_q] <= mem_rdata_i;
          rr_q                  <= ~owner_q;
          state_q               <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        init_mem;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  rdy;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] hold_exp   [2];
  bit          hold_valid [2];
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (req[0]),
    .m0_we_i     (we[0]),
    .m0_be_i     (be[0]),
    .m0_addr_i   (addr[0]),
    .m0_wdata_i  (wdata[0]),
    .m0_rdata_o  (rdata[0]),
    .m0_ready_o  (rdy[0]),
    .m1_req_i    (req[1]),
    .m1_we_i     (we[1]),
    .m1_be_i     (be[1]),
    .m1_addr_i   (addr[1]),
    .m1_wdata_i  (wdata[1]),
    .m1_rdata_o  (rdata[1]),
    .m1_ready_o  (rdy[1]),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready)
  );

  // Stand-in for data_mem: one-cycle synchronous read, byte-enabled write, no reset.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[4]    <= 32'hDEAD_BEEF;
      mem[8]    <= 32'h1122_3344;
      mem[12]   <= 32'h1234_5678;
      mem_rdata <= '0;
    end else if (mem_req && mem_ready) begin
      mem_rdata <= mem[mem_addr[7:2]];
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Requester-protocol monitor: attributes must stay stable while a request is pending.
  logic [68:0] a_prev [2];
  logic [1:0]  p_req, p_rdy;
  logic        p_rst;
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (p_req[p] && !p_rdy[p] && !p_rst && req[p] && !rst &&
          ({we[p], be[p], addr[p], wdata[p]} !== a_prev[p])) begin
        errors++;
        $display("FAIL protocol: port %0d attributes changed while pending", p);
      end
      a_prev[p] <= {we[p], be[p], addr[p], wdata[p]};
    end
    p_req <= req;
    p_rdy <= rdy;
    p_rst <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 2'b00;
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      hold_exp[p]   = '0;
      hold_valid[p] = 1'b1;
    end
  endtask

  // One isolated access on port p with `stalls` cycles of mem_ready low.
  task automatic access(input int p, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input int stalls,
                        input logic [31:0] exp_rd, input int exp_cycles);
    int   q;
    int   n;
    int   cycles;
    bit   done;
    logic [31:0] rd;
    q = 1 - p;
    n = 0;
    done = 1'b0;
    cycles = 0;
    rd = '0;
    req[p] = 1'b1; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d;
    mem_ready = (stalls == 0);
    while (!done && n < 40) begin
      settle();
      if (n == 0) begin
        chk("issue mem_req", 32'(mem_req), 32'd1);
        chk("issue mem_addr", mem_addr, a);
        chk("issue mem_we", 32'(mem_we), 32'(w));
      end
      chk("non-owner ready", 32'(rdy[q]), 32'd0);
      if (hold_valid[q]) chk("non-owner hold", rdata[q], hold_exp[q]);
      if (rdy[p]) begin
        done = 1'b1;
        rd = rdata[p];
        cycles = n + 1;
      end
      tick();
      n++;
      mem_ready = (n >= stalls);
    end
    req[p] = 1'b0;
    mem_ready = 1'b1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access timeout: port %0d addr %h got no ready required one", p, a);
    end else begin
      chk("access latency", 32'(cycles), 32'(exp_cycles));
      if (!w) chk("access rdata", rd, exp_rd);
    end
    if (w) hold_valid[p] = 1'b0;
    else begin
      hold_exp[p]   = exp_rd;
      hold_valid[p] = 1'b1;
    end
  endtask

  typedef struct {
    int          port;
    logic        w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] d;
    int          stalls;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  exp_rdy;
    int          grants [8];
    int          k [2];
    int          got, n, cnt0, idx, cyc, n_done, tie, m_own, gap [2];
    bit          pend [2];
    bit          m_active, m_acc, responding;

    vecs[0] = '{0, 1'b0, 4'h0, 32'h10, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 4'h4, 32'h20, 32'h00AB_0000, 0, 32'h0};
    vecs[2] = '{1, 1'b0, 4'h0, 32'h20, 32'h0,         0, 32'h11AB_3344};
    vecs[3] = '{0, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D, 2, 32'h0};
    vecs[4] = '{0, 1'b0, 4'h0, 32'h40, 32'h0,         1, 32'hCAFE_F00D};
    vecs[5] = '{1, 1'b1, 4'h1, 32'h44, 32'h0000_00EE, 0, 32'h0};
    vecs[6] = '{1, 1'b0, 4'h0, 32'h44, 32'h0,         3, 32'hA500_00EE};
    vecs[7] = '{0, 1'b1, 4'hA, 32'h48, 32'h7766_5544, 0, 32'h0};
    vecs[8] = '{0, 1'b0, 4'h0, 32'h48, 32'h0,         0, 32'h7700_5512};

    rst = 1'b1; init_mem = 1'b1; req = 2'b00; we = 2'b00; mem_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      be[p] = '0; addr[p] = '0; wdata[p] = '0; hold_exp[p] = '0; hold_valid[p] = 1'b1;
    end
    tick();
    init_mem = 1'b0;
    tick();

    // Reset state: outputs forced low even with a request present.
    req[0] = 1'b1; addr[0] = 32'h10;
    settle();
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset ready", 32'(rdy), 32'd0);
    chk("reset m0_rdata", rdata[0], 32'd0);
    chk("reset m1_rdata", rdata[1], 32'd0);
    req[0] = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("post-reset mem_req", 32'(mem_req), 32'd0);
    chk("post-reset mem_addr", mem_addr, 32'd0);
    chk("post-reset m0_rdata", rdata[0], 32'd0);
    tick();

    for (int i = 0; i < 9; i++)
      access(vecs[i].port, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d,
             vecs[i].stalls, vecs[i].exp_rd, vecs[i].stalls + 2);

    // Wait states: m1 pending with mem_ready low, m0 arrives meanwhile.
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h20; mem_ready = 1'b0;
    settle();
    chk("ws c0 mem_req", 32'(mem_req), 32'd1);
    chk("ws c0 mem_addr", mem_addr, 32'h20);
    tick();
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'h0; addr[0] = 32'h10;
    for (int c = 1; c < 4; c++) begin
      mem_ready = (c == 3);
      settle();
      chk("ws stall mem_req", 32'(mem_req), 32'd1);
      chk("ws stall mem_addr", mem_addr, 32'h20);
      chk("ws stall ready", 32'(rdy), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    chk("ws c4 ready", 32'(rdy), 32'b10);
    chk("ws c4 m1_rdata", rdata[1], 32'h11AB_3344);
    chk("ws c4 mem_req", 32'(mem_req), 32'd0);
    tick();
    req[1] = 1'b0;
    settle();
    chk("ws c5 m0 granted", mem_addr, 32'h10);
    tick();
    settle();
    chk("ws c6 ready", 32'(rdy), 32'b01);
    chk("ws c6 m0_rdata", rdata[0], 32'hDEAD_BEEF);
    tick();
    req[0] = 1'b0;
    hold_exp[0] = 32'hDEAD_BEEF; hold_exp[1] = 32'h11AB_3344;
    hold_valid[0] = 1'b1; hold_valid[1] = 1'b1;

    // Hold register: m0 data survives three m1 accesses.
    access(0, 1'b0, 4'h0, 32'h30, 32'h0, 0, 32'h1234_5678, 2);
    access(1, 1'b0, 4'h0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 2);
    access(1, 1'b1, 4'hF, 32'h24, 32'h5555_AAAA, 1, 32'h0, 3);
    access(1, 1'b0, 4'h0, 32'h24, 32'h0, 0, 32'h5555_AAAA, 2);
    chk("hold m0_rdata", rdata[0], 32'h1234_5678);

    // Contention from reset: both request continuously, 4 reads each.
    do_reset();
    k[0] = 0; k[1] = 0; got = 0; n = 0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b1; we[p] = 1'b0; be[p] = 4'h0; addr[p] = 32'h80 + 32'(4 * p);
    end
    while (got < 8 && n < 100) begin
      settle();
      chk("contention one ready", 32'(rdy == 2'b11), 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (rdy[p]) begin
          grants[got] = p;
          chk("contention rdata", rdata[p], 32'hA500_0000 | 32'(32 + 2 * k[p] + p));
          k[p]++;
          got++;
        end
      end
      tick();
      n++;
      for (int p = 0; p < 2; p++) begin
        if (req[p] && (addr[p] != 32'h80 + 32'(8 * k[p] + 4 * p))) begin
          if (k[p] < 4) addr[p] = 32'h80 + 32'(8 * k[p] + 4 * p);
          else req[p] = 1'b0;
        end
      end
    end
    req = 2'b00;
    if (got < 8) begin
      checks++; errors++;
      $display("FAIL contention timeout: got %0d grants required 8", got);
    end
    cnt0 = 0;
    for (int i = 0; i < got; i++) begin
      chk("contention order", 32'(grants[i]), 32'(i % 2));
      if (grants[i] == 0) cnt0++;
    end
    chk("contention m0 count", 32'(cnt0), 32'd4);
    tick();

    // Reset in RESP: no ready, everything cleared, rr pointer back to m0.
    do_reset();
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 2);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h30;
    settle();
    chk("rst-mid issue", 32'(mem_req), 32'd1);
    tick();
    rst = 1'b1;
    settle();
    chk("rst-mid ready", 32'(rdy), 32'd0);
    chk("rst-mid mem_req", 32'(mem_req), 32'd0);
    chk("rst-mid m0_rdata", rdata[0], 32'd0);
    tick();
    rst = 1'b0; req[0] = 1'b0;
    settle();
    chk("after rst ready", 32'(rdy), 32'd0);
    chk("after rst mem_req", 32'(mem_req), 32'd0);
    chk("after rst bus", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
    chk("after rst m0_rdata", rdata[0], 32'd0);
    chk("after rst m1_rdata", rdata[1], 32'd0);
    tick();
    req = 2'b11; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h20;
    settle();
    chk("after rst m0 wins", mem_addr, 32'h10);
    tick();
    settle();
    chk("after rst m0 ready", 32'(rdy), 32'b01);
    chk("after rst m0 data", rdata[0], 32'hDEAD_BEEF);
    tick();
    req[0] = 1'b0;
    settle();
    chk("after rst m1 next", mem_addr, 32'h20);
    tick();
    settle();
    chk("after rst m1 ready", 32'(rdy), 32'b10);
    chk("after rst m1 data", rdata[1], 32'h11AB_3344);
    tick();
    req[1] = 1'b0;

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    tie = 0; m_active = 1'b0; m_acc = 1'b0; m_own = 0; cyc = 0; n_done = 0;
    for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; gap[p] = p; end
    while (n_done < 300 && cyc < 5000) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if (gap[p] == 0) begin
            pend[p]  = 1'b1;
            we[p]    = ($urandom_range(0, 2) == 0);
            be[p]    = 4'($urandom);
            addr[p]  = {24'h0, 6'($urandom), 2'b00};
            wdata[p] = $urandom;
          end else gap[p]--;
        end
        req[p] = pend[p];
      end
      mem_ready = ($urandom_range(0, 9) < 7);
      settle();
      exp_rdy = 2'b00;
      responding = m_active && m_acc;
      if (responding) begin
        exp_rdy[m_own] = 1'b1;
        chk("rnd resp mem_req", 32'(mem_req), 32'd0);
      end else begin
        if (!m_active && (req != 2'b00)) begin
          m_own    = (req == 2'b11) ? tie : (req[1] ? 1 : 0);
          m_active = 1'b1;
          m_acc    = 1'b0;
        end
        if (m_active) begin
          chk("rnd mem_req", 32'(mem_req), 32'd1);
          chk("rnd mem_addr", mem_addr, addr[m_own]);
          chk("rnd mem_we", 32'(mem_we), 32'(we[m_own]));
          if (mem_ready) m_acc = 1'b1;
        end else chk("rnd idle mem_req", 32'(mem_req), 32'd0);
      end
      chk("rnd ready", 32'(rdy), 32'(exp_rdy));
      for (int q = 0; q < 2; q++)
        if (!(responding && q == m_own) && hold_valid[q])
          chk("rnd hold", rdata[q], hold_exp[q]);
      if (responding) begin
        idx = int'(addr[m_own][7:2]);
        if (!we[m_own]) begin
          chk("rnd rdata", rdata[m_own], ref_mem[idx]);
          hold_exp[m_own]   = ref_mem[idx];
          hold_valid[m_own] = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (be[m_own][b]) ref_mem[idx][8*b +: 8] = wdata[m_own][8*b +: 8];
          hold_valid[m_own] = 1'b0;
        end
        tie = 1 - m_own;
        m_active = 1'b0;
        m_acc = 1'b0;
        pend[m_own] = 1'b0;
        gap[m_own] = $urandom_range(0, 3);
        n_done++;
      end
      tick();
      cyc++;
    end
    req = 2'b00;
    if (n_done < 300) begin
      checks++; errors++;
      $display("FAIL random timeout: completed %0d accesses required 300", n_done);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
